lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store control stage between the execute stage and the data memory.
- Accepts one memory request per handshake and decodes the RISC-V funct3 into the data-memory `lsbwh` encoding.
- Checks alignment and address range; faulting requests never reach memory and raise a one-cycle fault.
- Drives the memory's chip-select/read/write strobes for one access cycle, then returns load data to writeback with a valid/ready handshake.

Parameters:
- DMEM_WORDS, 2048, number of 32-bit words in data memory; word index `addr[31:2]` must be below this value.
- ADDR_W, 32, width of the byte address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  block accepts a request; high only in IDLE.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  load destination register.
- daddr  out  ADDR_W  memory byte address.
- dwdata  out  32  memory write data.
- cs  out  1  memory chip select, active-low.
- wr  out  1  write strobe, informational.
- rd  out  1  memory read; a low `rd` together with low `cs` means write.
- lsbwh  out  3  memory size/sign select.
- d_rdata  in  32  memory read data; combinational, already extended.
- wb_valid  out  1  load result available.
- wb_ready  in  1  writeback consumes the result.
- wb_rd  out  5  destination register.
- wb_data  out  32  load result.
- store_done  out  1  one-cycle pulse when a store completes.
- fault_valid  out  1  one-cycle fault pulse.
- fault_cause  out  2  fault type: 0 misaligned, 1 out of range, 2 illegal op.
- fault_addr  out  ADDR_W  faulting address.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - `cs`=1, `rd`=1, `wr`=0, `lsbwh`=0, `daddr`=0, `dwdata`=0.
  - `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `store_done`=0, `fault_valid`=0, `fault_cause`=0, `fault_addr`=0.
  - A reset asserted during ACCESS aborts the access: `cs` and `rd` go high asynchronously, so no memory write occurs.
- Outside ACCESS, memory strobes are `cs`=1, `rd`=1, `wr`=0. Holding `rd` high guarantees no spurious write.
- Handshake:
  - A request is accepted on a rising edge where `req_valid` and `req_ready` are both high.
  - All `req_*` inputs are registered at acceptance; later input changes are ignored.
- Decode, loads:
  - funct3 000 → `lsbwh` 4
  - funct3 001 → `lsbwh` 1
  - funct3 010 → `lsbwh` 0
  - funct3 100 → `lsbwh` 3
  - funct3 101 → `lsbwh` 2
- Decode, stores:
  - funct3 000 → `lsbwh` 2
  - funct3 001 → `lsbwh` 1
  - funct3 010 → `lsbwh` 0
- Fault checks at acceptance, in priority order:
  - Illegal op (cause 2): funct3 not in the tables above, `req_load` and `req_store` both set, or both clear.
  - Misaligned (cause 0): halfword access with `addr[0]`=1, or word access with `addr[1:0]`≠0.
  - Out of range (cause 1): `addr[31:2]` ≥ DMEM_WORDS.
- FSM states: IDLE, ACCESS, RESP, FAULT.
  - IDLE: `req_ready`=1. An accepted faulting request goes to FAULT; an accepted good request goes to ACCESS.
  - FAULT (1 cycle): `fault_valid`=1 with `fault_cause` and `fault_addr` held; no memory strobe; then IDLE.
  - ACCESS (exactly 1 cycle): `cs`=0, `daddr` and `lsbwh` from the registered request.
    - Store: `rd`=0, `wr`=1, `dwdata`=registered data. Memory commits on the falling edge inside this cycle. Next state IDLE, with `store_done` pulsing 1 cycle in the first IDLE cycle.
    - Load: `rd`=1, `wr`=0. `wb_data` captures `d_rdata` at the closing rising edge; `wb_rd` loads with it. Next state RESP.
  - RESP: `wb_valid`=1; `wb_data` and `wb_rd` held stable. Go to IDLE on the edge where `wb_ready`=1, otherwise stay.
- Latency:
  - Load: accept edge to `wb_valid` = 2 cycles.
  - Store: accept edge to `store_done` = 2 cycles.
  - Fault: accept edge to `fault_valid` = 1 cycle.
  - Back-to-back throughput: one request per 2 cycles for stores, ≥3 cycles for loads.
- Loads to x0 still complete normally with `wb_rd`=0.

Test Plan:
- Reset low mid-ACCESS of SW to 0x10 → `cs` goes high immediately; after reset release, a load of 0x10 returns the old value (0).
- SW 0xDEADBEEF to 0x40, then LW 0x40 → `store_done` at cycle 2; `wb_valid` at cycle 2 of the load with `wb_data`=0xDEADBEEF and `wb_rd` echoed.
- SB 0x7F to 0x41, then LB 0x41 and LBU 0x43 → LB returns 0x0000007F. LBU returns 0x000000DE: bytes 0, 2 and 3 (0xEF, 0xAD, 0xDE) are untouched by the SB to 0x41.
- SH 0x8001 to 0x42, then LH 0x42 and LHU 0x42 → LH returns 0xFFFF8001; LHU returns 0x00008001.
- LW 0x45 → `fault_valid`=1, cause 0, `fault_addr`=0x45, `cs` never low. SW 0x2000 with DMEM_WORDS=2048 → cause 1. funct3 011 → cause 2.
- LW with `wb_ready` held low for 5 cycles → `wb_valid` and `wb_data` stable all 5 cycles and `req_ready`=0; the state returns to IDLE on the edge where `wb_ready`=1.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Load/store control bus: execute request, data memory strobes,
// writeback handshake and fault report, grouped for lsu_ctrl.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic [ADDR_W-1:0] daddr;
    logic [31:0]       dwdata;
    logic              cs;
    logic              wr;
    logic              rd;
    logic [2:0]        lsbwh;
    logic [31:0]       d_rdata;

    logic              wb_valid;
    logic              wb_ready;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;

    logic              store_done;
    logic              fault_valid;
    logic [1:0]        fault_cause;
    logic [ADDR_W-1:0] fault_addr;

    // Environment side: execute stage, data memory, writeback.
    modport master (
        output req_valid, req_load, req_store,
        output req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  daddr, dwdata, cs, wr, rd, lsbwh,
        output d_rdata,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready,
        input  store_done, fault_valid, fault_cause, fault_addr
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_load, req_store,
        input  req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output daddr, dwdata, cs, wr, rd, lsbwh,
        input  d_rdata,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready,
        output store_done, fault_valid, fault_cause, fault_addr
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control stage between execute and data memory.
// Ports: clk, reset (async active-low), bus (lsu_ctrl_if.slave):
//   req_*  execute request, valid/ready handshake
//   daddr/dwdata/cs/wr/rd/lsbwh/d_rdata  data memory access
//   wb_*   load result to writeback, valid/ready handshake
//   store_done, fault_*  one-cycle completion / fault pulses
module lsu_ctrl #(
    parameter int DMEM_WORDS = 2048,
    parameter int ADDR_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    lsu_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        FAULT
    } state_t;

    state_t            state;

    logic              is_store_q;
    logic [4:0]        rd_q;

    logic [ADDR_W-1:0] daddr_q;
    logic [31:0]       dwdata_q;
    logic              cs_q;
    logic              wr_q;
    logic              rd_strobe_q;
    logic [2:0]        lsbwh_q;

    logic              wb_valid_q;
    logic [4:0]        wb_rd_q;
    logic [31:0]       wb_data_q;

    logic              store_done_q;
    logic              fault_valid_q;
    logic [1:0]        fault_cause_q;
    logic [ADDR_W-1:0] fault_addr_q;

    logic              op_ok;
    logic              need_h;
    logic              need_w;
    logic [2:0]        dec_lsbwh;
    logic              misal;
    logic              oor;
    logic              is_fault;
    logic [1:0]        cause;

    // funct3 -> memory size/sign select; loads and stores use
    // different tables, and exactly one of load/store must be set.
    always_comb begin
        op_ok     = 1'b0;
        need_h    = 1'b0;
        need_w    = 1'b0;
        dec_lsbwh = 3'd0;
        if (bus.req_load && !bus.req_store) begin
            case (bus.req_funct3)
                3'b000: begin op_ok = 1'b1; dec_lsbwh = 3'd4; end
                3'b001: begin
                    op_ok = 1'b1; dec_lsbwh = 3'd1; need_h = 1'b1;
                end
                3'b010: begin
                    op_ok = 1'b1; dec_lsbwh = 3'd0; need_w = 1'b1;
                end
                3'b100: begin op_ok = 1'b1; dec_lsbwh = 3'd3; end
                3'b101: begin
                    op_ok = 1'b1; dec_lsbwh = 3'd2; need_h = 1'b1;
                end
                default: op_ok = 1'b0;
            endcase
        end else if (bus.req_store && !bus.req_load) begin
            case (bus.req_funct3)
                3'b000: begin op_ok = 1'b1; dec_lsbwh = 3'd2; end
                3'b001: begin
                    op_ok = 1'b1; dec_lsbwh = 3'd1; need_h = 1'b1;
                end
                3'b010: begin
                    op_ok = 1'b1; dec_lsbwh = 3'd0; need_w = 1'b1;
                end
                default: op_ok = 1'b0;
            endcase
        end
    end

    assign misal = (need_h && bus.req_addr[0]) ||
                   (need_w && (bus.req_addr[1:0] != 2'b00));

    // Word index compared at full address width.
    assign oor = {2'b00, bus.req_addr[ADDR_W-1:2]} >=
                 ADDR_W'(DMEM_WORDS);

    assign is_fault = !op_ok || misal || oor;

    // Priority: illegal op, then misalignment, then range.
    assign cause = !op_ok ? 2'd2 :
                   misal  ? 2'd0 :
                            2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            is_store_q    <= 1'b0;
            rd_q          <= 5'd0;
            daddr_q       <= '0;
            dwdata_q      <= 32'd0;
            cs_q          <= 1'b1;
            wr_q          <= 1'b0;
            rd_strobe_q   <= 1'b1;
            lsbwh_q       <= 3'd0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= 32'd0;
            store_done_q  <= 1'b0;
            fault_valid_q <= 1'b0;
            fault_cause_q <= 2'd0;
            fault_addr_q  <= '0;
        end else begin
            store_done_q  <= 1'b0;
            fault_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (is_fault) begin
                            state         <= FAULT;
                            fault_valid_q <= 1'b1;
                            fault_cause_q <= cause;
                            fault_addr_q  <= bus.req_addr;
                        end else begin
                            state       <= ACCESS;
                            is_store_q  <= bus.req_store;
                            rd_q        <= bus.req_rd;
                            daddr_q     <= bus.req_addr;
                            dwdata_q    <= bus.req_wdata;
                            lsbwh_q     <= dec_lsbwh;
                            cs_q        <= 1'b0;
                            wr_q        <= bus.req_store;
                            rd_strobe_q <= !bus.req_store;
                        end
                    end
                end
                ACCESS: begin
                    cs_q        <= 1'b1;
                    wr_q        <= 1'b0;
                    rd_strobe_q <= 1'b1;
                    if (is_store_q) begin
                        state        <= IDLE;
                        store_done_q <= 1'b1;
                    end else begin
                        state      <= RESP;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= bus.d_rdata;
                        wb_rd_q    <= rd_q;
                    end
                end
                RESP: begin
                    if (bus.wb_ready) begin
                        state      <= IDLE;
                        wb_valid_q <= 1'b0;
                    end
                end
                FAULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state == IDLE);
    assign bus.daddr       = daddr_q;
    assign bus.dwdata      = dwdata_q;
    assign bus.cs          = cs_q;
    assign bus.wr          = wr_q;
    assign bus.rd          = rd_strobe_q;
    assign bus.lsbwh       = lsbwh_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.store_done  = store_done_q;
    assign bus.fault_valid = fault_valid_q;
    assign bus.fault_cause = fault_cause_q;
    assign bus.fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressed memory model.
// Memory writes on the falling edge while cs=0 and rd=0.
module tb_lsu_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    lsu_ctrl_if #(.ADDR_W(32)) bus ();

    lsu_ctrl #(
        .DMEM_WORDS(2048),
        .ADDR_W    (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:8191];
    logic [12:0] ra;
    logic [31:0] rdata_m;

    initial begin
        logic [12:0] wa;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (!bus.cs && !bus.rd) begin
                wa = bus.daddr[12:0];
                case (bus.lsbwh)
                    3'd0: begin
                        mem[wa]         = bus.dwdata[7:0];
                        mem[wa + 13'd1] = bus.dwdata[15:8];
                        mem[wa + 13'd2] = bus.dwdata[23:16];
                        mem[wa + 13'd3] = bus.dwdata[31:24];
                    end
                    3'd1: begin
                        mem[wa]         = bus.dwdata[7:0];
                        mem[wa + 13'd1] = bus.dwdata[15:8];
                    end
                    3'd2: mem[wa] = bus.dwdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ra      = bus.daddr[12:0];
        rdata_m = 32'd0;
        case (bus.lsbwh)
            3'd0: rdata_m = {mem[ra + 13'd3], mem[ra + 13'd2],
                             mem[ra + 13'd1], mem[ra]};
            3'd1: rdata_m = {{16{mem[ra + 13'd1][7]}},
                             mem[ra + 13'd1], mem[ra]};
            3'd2: rdata_m = {16'h0000, mem[ra + 13'd1], mem[ra]};
            3'd3: rdata_m = {24'h000000, mem[ra]};
            3'd4: rdata_m = {{24{mem[ra][7]}}, mem[ra]};
            default: rdata_m = 32'd0;
        endcase
    end

    assign bus.d_rdata = rdata_m;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.req_load   = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'hA5A5_A5A5;
        bus.req_rd     = 5'd31;
    endtask

    // Called just after a rising edge with the DUT in IDLE; returns
    // 1 time unit after the accepting edge with inputs scrambled.
    task automatic issue(input logic ld, input logic st,
                         input logic [2:0] f3,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [4:0] rdn);
        check("req_ready_pre", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_load   = ld;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rdn;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_store(input logic [2:0] f3,
                            input logic [31:0] addr,
                            input logic [31:0] data,
                            input logic [2:0] exp_lsbwh);
        issue(1'b0, 1'b1, f3, addr, data, 5'd0);
        check("st_cs", {31'd0, bus.cs}, 32'd0);
        check("st_rd", {31'd0, bus.rd}, 32'd0);
        check("st_wr", {31'd0, bus.wr}, 32'd1);
        check("st_daddr", bus.daddr, addr);
        check("st_dwdata", bus.dwdata, data);
        check("st_lsbwh", {29'd0, bus.lsbwh}, {29'd0, exp_lsbwh});
        @(posedge clk);
        #1;
        check("st_done", {31'd0, bus.store_done}, 32'd1);
        check("st_cs_off", {31'd0, bus.cs}, 32'd1);
        check("st_rdy", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic do_load(input logic [2:0] f3,
                           input logic [31:0] addr,
                           input logic [4:0] rdn,
                           input logic [2:0] exp_lsbwh,
                           input logic [31:0] exp_data);
        issue(1'b1, 1'b0, f3, addr, 32'h0, rdn);
        check("ld_cs", {31'd0, bus.cs}, 32'd0);
        check("ld_rd", {31'd0, bus.rd}, 32'd1);
        check("ld_lsbwh", {29'd0, bus.lsbwh}, {29'd0, exp_lsbwh});
        check("ld_busy", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("ld_wbv", {31'd0, bus.wb_valid}, 32'd1);
        check("ld_data", bus.wb_data, exp_data);
        check("ld_wbrd", {27'd0, bus.wb_rd}, {27'd0, rdn});
        check("ld_cs_off", {31'd0, bus.cs}, 32'd1);
        @(posedge clk);
        #1;
        check("ld_wbv_off", {31'd0, bus.wb_valid}, 32'd0);
    endtask

    task automatic do_fault(input logic ld, input logic st,
                            input logic [2:0] f3,
                            input logic [31:0] addr,
                            input logic [1:0] exp_cause);
        issue(ld, st, f3, addr, 32'h1234_5678, 5'd7);
        check("flt_valid", {31'd0, bus.fault_valid}, 32'd1);
        check("flt_cause", {30'd0, bus.fault_cause},
              {30'd0, exp_cause});
        check("flt_addr", bus.fault_addr, addr);
        check("flt_cs", {31'd0, bus.cs}, 32'd1);
        check("flt_rd", {31'd0, bus.rd}, 32'd1);
        @(posedge clk);
        #1;
        check("flt_pulse", {31'd0, bus.fault_valid}, 32'd0);
        check("flt_cs2", {31'd0, bus.cs}, 32'd1);
        check("flt_rdy", {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        idle_inputs();
        bus.wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cs", {31'd0, bus.cs}, 32'd1);
        check("rst_rd", {31'd0, bus.rd}, 32'd1);
        check("rst_wr", {31'd0, bus.wr}, 32'd0);
        check("rst_lsbwh", {29'd0, bus.lsbwh}, 32'd0);
        check("rst_daddr", bus.daddr, 32'd0);
        check("rst_dwdata", bus.dwdata, 32'd0);
        check("rst_wbv", {31'd0, bus.wb_valid}, 32'd0);
        check("rst_wbdata", bus.wb_data, 32'd0);
        check("rst_fault", {31'd0, bus.fault_valid}, 32'd0);
        check("rst_sdone", {31'd0, bus.store_done}, 32'd0);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Abort a store mid-ACCESS before the memory's falling edge.
        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'h1234_5678, 5'd0);
        check("abort_cs_on", {31'd0, bus.cs}, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        check("abort_cs", {31'd0, bus.cs}, 32'd1);
        check("abort_rd", {31'd0, bus.rd}, 32'd1);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_load(3'b010, 32'h10, 5'd3, 3'd0, 32'h0000_0000);

        // Word store / load.
        do_store(3'b010, 32'h40, 32'hDEAD_BEEF, 3'd0);
        do_load(3'b010, 32'h40, 5'd5, 3'd0, 32'hDEAD_BEEF);

        // Byte store into byte 1, neighbours untouched.
        do_store(3'b000, 32'h41, 32'h0000_007F, 3'd2);
        do_load(3'b000, 32'h41, 5'd6, 3'd4, 32'h0000_007F);
        do_load(3'b100, 32'h43, 5'd7, 3'd3, 32'h0000_00DE);
        do_load(3'b000, 32'h40, 5'd8, 3'd4, 32'hFFFF_FFEF);

        // Halfword store, signed and unsigned reload.
        do_store(3'b001, 32'h42, 32'h0000_8001, 3'd1);
        do_load(3'b001, 32'h42, 5'd9, 3'd1, 32'hFFFF_8001);
        do_load(3'b101, 32'h42, 5'd10, 3'd2, 32'h0000_8001);
        do_load(3'b010, 32'h40, 5'd11, 3'd0, 32'h8001_7FEF);

        // Last in-range word.
        do_store(3'b010, 32'h1FFC, 32'hCAFE_F00D, 3'd0);
        do_load(3'b010, 32'h1FFC, 5'd12, 3'd0, 32'hCAFE_F00D);

        // Faults and their priority.
        do_fault(1'b1, 1'b0, 3'b010, 32'h45, 2'd0);
        do_fault(1'b0, 1'b1, 3'b010, 32'h2000, 2'd1);
        do_fault(1'b1, 1'b0, 3'b011, 32'h40, 2'd2);
        do_fault(1'b1, 1'b1, 3'b010, 32'h40, 2'd2);
        do_fault(1'b0, 1'b0, 3'b010, 32'h40, 2'd2);
        do_fault(1'b0, 1'b1, 3'b100, 32'h40, 2'd2);
        do_fault(1'b1, 1'b0, 3'b001, 32'h43, 2'd0);
        do_fault(1'b1, 1'b0, 3'b010, 32'h2001, 2'd0);
        do_fault(1'b1, 1'b0, 3'b011, 32'h2001, 2'd2);
        do_load(3'b010, 32'h40, 5'd13, 3'd0, 32'h8001_7FEF);

        // Writeback back-pressure on a load to x0.
        bus.wb_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_wbv", {31'd0, bus.wb_valid}, 32'd1);
            check("stall_data", bus.wb_data, 32'h8001_7FEF);
            check("stall_wbrd", {27'd0, bus.wb_rd}, 32'd0);
            check("stall_busy", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.wb_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release", {31'd0, bus.req_ready}, 32'd1);
        check("stall_wbv_off", {31'd0, bus.wb_valid}, 32'd0);

        // Back-to-back stores at one per two cycles.
        do_store(3'b010, 32'h80, 32'h1111_2222, 3'd0);
        do_store(3'b010, 32'h84, 32'h3333_4444, 3'd0);
        do_load(3'b010, 32'h80, 5'd14, 3'd0, 32'h1111_2222);
        do_load(3'b010, 32'h84, 5'd15, 3'd0, 32'h3333_4444);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
